// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/writeback controller wrapped around the combinational MIPS ALU
module alu_issue_ctrl #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] pc,
  output logic        done,
  output logic        ovf_exc,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);
  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
  state_t state_q, state_d;
  logic [31:0] ir_q, res_q, rdata_q, pc_q;
  logic [2:0]  flags_q;
  logic [31:0] rf_q [32];
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, dst;
  logic        exec, is_lw, is_sw, is_beq, is_bne, r_ok, i_wr, is_slt, trap_op, wr_en, taken;
  logic [31:0] wdata, pc_inc, br_off;
  assign op      = ir_q[31:26];
  assign fn      = ir_q[5:0];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2b;
  assign is_beq  = op == 6'h04;
  assign is_bne  = op == 6'h05;
  assign r_ok    = op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h2a, 6'h2b}
                   || fn[5:3] == 3'b100);
  assign i_wr    = op inside {[6'h08:6'h0e]} || is_lw;
  assign is_slt  = (op == 6'h00 && (fn == 6'h2a || fn == 6'h2b)) || op == 6'h0a || op == 6'h0b;
  assign trap_op = (op == 6'h00 && (fn == 6'h20 || fn == 6'h22)) || op == 6'h08;
  assign dst     = r_ok ? rd : rt;
  assign wr_en   = state_q == WB && (r_ok || i_wr) && !(trap_op && flags_q[0]) && dst != 5'd0;
  assign wdata   = is_slt ? {31'b0, flags_q[1]} : is_lw ? rdata_q : res_q;
  assign taken   = (is_beq && flags_q[2]) || (is_bne && !flags_q[2]);
  assign pc_inc  = pc_q + 32'd4;
  assign br_off  = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = instr_valid ? EXEC : IDLE;
      EXEC:    state_d = (is_lw || is_sw) ? MEM : WB;
      MEM:     state_d = mem_ack ? WB : MEM;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      rdata_q <= '0;
      pc_q    <= PC_RESET;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && instr_valid) ir_q <= instr;
      if (exec) begin
        res_q   <= alu_result;
        flags_q <= alu_flags;
      end
      if (mem_req && mem_ack) rdata_q <= mem_rdata;
      if (wr_en) rf_q[dst] <= wdata;
      if (state_q == WB) pc_q <= taken ? pc_inc + br_off : pc_inc;
    end
  end
  assign exec            = state_q == EXEC;
  assign instr_ready     = state_q == IDLE;
  assign alu_instruction = exec ? ir_q : '0;
  // The ALU swaps rs/rt internally unless rs is $0, so present them pre-swapped
  assign alu_regA        = exec ? (rs == 5'd0 ? rf_q[rs] : rf_q[rt]) : '0;
  assign alu_regB        = exec ? (rs == 5'd0 ? rf_q[rt] : rf_q[rs]) : '0;
  assign mem_req         = state_q == MEM;
  assign mem_we          = mem_req && is_sw;
  assign mem_addr        = mem_req ? res_q : '0;
  assign mem_wdata       = mem_req ? rf_q[rt] : '0;
  assign done            = state_q == WB;
  assign ovf_exc         = done && trap_op && flags_q[0];
  assign pc              = pc_q;
  assign dbg_data        = dbg_addr == 5'd0 ? '0 : rf_q[dbg_addr];
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed checks of issue timing, writeback, branches, overflow and memory handshake
module tb_alu_issue_ctrl;
  logic        clk = 0, reset = 1, instr_valid = 0, instr_ready;
  logic [31:0] instr = 0, alu_instruction, alu_regA, alu_regB, alu_result = 0;
  logic [2:0]  alu_flags = 0;
  logic        mem_req, mem_we, mem_ack = 0, done, ovf_exc;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = 0, pc, dbg_data;
  logic [4:0]  dbg_addr = 0;
  logic [31:0] obs_a, obs_b;
  int          tests = 0, fails = 0, nz;
  alu_issue_ctrl u_dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_instruction(alu_instruction), .alu_regA(alu_regA), .alu_regB(alu_regB),
    .alu_result(alu_result), .alu_flags(alu_flags), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .done(done), .ovf_exc(ovf_exc), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask
  task automatic chk_rf_clear();
    nz = 0;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = 5'(a);
      #1;
      if (dbg_data !== 32'd0) nz++;
    end
    check("rf_clear", 32'(nz), 0);
  endtask
  task automatic run_alu(input logic [31:0] ins, input logic [31:0] res, input logic [2:0] flg,
                         input logic ovf);
    @(negedge clk);
    check("ready", 32'(instr_ready), 1);
    instr = ins; instr_valid = 1; alu_result = res; alu_flags = flg;
    @(negedge clk);
    instr = ~ins;
    check("exec_ready", 32'(instr_ready), 0);
    check("alu_instr", alu_instruction, ins);
    check("exec_done", 32'(done), 0);
    obs_a = alu_regA; obs_b = alu_regB;
    @(negedge clk);
    instr_valid = 0;
    check("done", 32'(done), 1);
    check("ovf", 32'(ovf_exc), 32'(ovf));
  endtask
  task automatic run_mem(input logic [31:0] ins, input logic [31:0] addr, input int dly,
                         input logic [31:0] rd, input logic we, input logic [31:0] wd);
    int hi = 0;
    @(negedge clk);
    instr = ins; instr_valid = 1; alu_result = addr; alu_flags = 0;
    @(negedge clk);
    instr_valid = 0; mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
    check("exec_no_req", 32'(mem_req), 0);
    for (int i = 0; i <= dly; i++) begin
      @(negedge clk);
      mem_ack = (i == dly);
      mem_rdata = (i == dly) ? rd : 32'hBAD0BAD0;
      hi += int'(mem_req);
      check("mem_addr", mem_addr, addr);
      check("mem_we", 32'(mem_we), 32'(we));
      check("mem_wdata", mem_wdata, wd);
      check("mem_wait_done", 32'(done), 0);
    end
    @(negedge clk);
    mem_ack = 0;
    check("mem_req_cycles", 32'(hi), 32'(dly + 1));
    check("mem_done", 32'(done), 1);
    check("mem_req_off", 32'(mem_req), 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset = 0;
    check("rst_pc", pc, 0);
    check("rst_ready", 32'(instr_ready), 1);
    check("rst_done", 32'(done), 0);
    check("rst_req", 32'(mem_req), 0);
    check("rst_alu", alu_instruction, 0);
    run_alu(32'h20010005, 32'h00000005, 3'b000, 0);
    run_alu(32'h2002FFFD, 32'hFFFFFFFD, 3'b000, 0);
    run_alu(32'h00221820, 32'h00000002, 3'b000, 0);
    check("add_regA", obs_a, 32'hFFFFFFFD);
    check("add_regB", obs_b, 32'h00000005);
    @(negedge clk);
    check("seq_pc", pc, 32'hC);
    chk_reg("seq_r1", 1, 32'h5);
    chk_reg("seq_r2", 2, 32'hFFFFFFFD);
    chk_reg("seq_r3", 3, 32'h2);
    chk_reg("seq_r0", 0, 32'h0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst2_pc", pc, 0);
    chk_rf_clear();
    run_alu(32'h3401FFFF, 32'h0000FFFF, 3'b000, 0);
    run_alu(32'h00010BC0, 32'h7FFF8000, 3'b000, 0);
    @(negedge clk);
    chk_reg("sll_r1", 1, 32'h7FFF8000);
    run_alu(32'h00211020, 32'hFFFF0000, 3'b001, 1);
    check("ovf_regA", obs_a, 32'h7FFF8000);
    @(negedge clk);
    chk_reg("ovf_r2", 2, 32'h0);
    run_alu(32'h00211021, 32'hFFFF0000, 3'b001, 0);
    @(negedge clk);
    chk_reg("addu_r2", 2, 32'hFFFF0000);
    check("br_start_pc", pc, 32'h10);
    run_alu(32'h10210003, 32'h0, 3'b100, 0);
    @(negedge clk);
    check("beq_taken", pc, 32'h20);
    run_alu(32'h1021FFFF, 32'h0, 3'b100, 0);
    @(negedge clk);
    check("beq_self", pc, 32'h20);
    run_alu(32'h14210003, 32'h0, 3'b100, 0);
    @(negedge clk);
    check("bne_not_taken", pc, 32'h24);
    run_alu(32'h14210003, 32'h1, 3'b000, 0);
    @(negedge clk);
    check("bne_taken", pc, 32'h34);
    run_alu(32'h10210003, 32'h1, 3'b000, 0);
    @(negedge clk);
    check("beq_not_taken", pc, 32'h38);
    run_alu(32'h20010005, 32'h00000005, 3'b000, 0);
    run_alu(32'h2002FFFD, 32'hFFFFFFFD, 3'b000, 0);
    run_alu(32'h0041202A, 32'hAAAA5555, 3'b010, 0);
    check("slt_regA", obs_a, 32'h5);
    check("slt_regB", obs_b, 32'hFFFFFFFD);
    @(negedge clk);
    chk_reg("slt_r4", 4, 32'h1);
    run_alu(32'h0041202B, 32'hAAAA5555, 3'b000, 0);
    @(negedge clk);
    chk_reg("sltu_r4", 4, 32'h0);
    run_alu(32'h28240006, 32'hAAAA5555, 3'b010, 0);
    @(negedge clk);
    chk_reg("slti_r4", 4, 32'h1);
    run_alu(32'hFC040000, 32'h00000055, 3'b000, 0);
    run_alu(32'h00002008, 32'h00000055, 3'b000, 0);
    @(negedge clk);
    chk_reg("unsup_r4", 4, 32'h1);
    check("unsup_pc", pc, 32'h54);
    run_mem(32'hAC010008, 32'h8, 3, 32'h0, 1, 32'h5);
    run_mem(32'h8C050008, 32'h8, 1, 32'hDEADBEEF, 0, 32'h0);
    @(negedge clk);
    chk_reg("lw_r5", 5, 32'hDEADBEEF);
    check("mem_pc", pc, 32'h5C);
    @(negedge clk);
    instr = 32'hAC010008; instr_valid = 1; alu_result = 32'h8;
    @(negedge clk);
    instr_valid = 0;
    @(negedge clk);
    check("rmem_req", 32'(mem_req), 1);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0; mem_ack = 1;
    check("rmem_req_drop", 32'(mem_req), 0);
    check("rmem_done", 32'(done), 0);
    check("rmem_ready", 32'(instr_ready), 1);
    check("rmem_pc", pc, 0);
    @(negedge clk);
    mem_ack = 0;
    check("rmem_late_ack", 32'(mem_req), 0);
    check("rmem_late_done", 32'(done), 0);
    chk_rf_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Multi-cycle issue/writeback controller that drives the combinational MIPS `alu` from the instruction side. It accepts one 32-bit MIPS instruction per handshake and reads operands from an internal 32×32 register file. It presents `instruction`/`regA`/`regB` to the ALU, then consumes `result`/`flags`, performing register writeback, branch resolution on the PC, and load/store through a req/ack data-memory port. It sits between the instruction source and the ALU, and forms the sequential core of the CPU datapath.

## Interface
- `PC_RESET`, default 32'h0000_0000: PC value after reset.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `instr_valid`  in  1: instruction source has `instr` available.
- `instr_ready`  out  1: controller can accept an instruction (IDLE only).
- `instr`  in  32: MIPS instruction word.
- `alu_instruction`, `alu_regA`, `alu_regB`  out  32 each: to ALU `instruction`, `regA`, `regB`.
- `alu_result`  in  32; `alu_flags`  in  3: from ALU. [0] = overflow, [1] = less-than, [2] = zero.
- `mem_req`  out  1; `mem_we`  out  1; `mem_addr`  out  32; `mem_wdata`  out  32: data-memory request.
- `mem_rdata`  in  32; `mem_ack`  in  1: memory response, one-cycle pulse.
- `pc`  out  32: byte address of the current/next instruction.
- `done`  out  1: one-cycle pulse per retired instruction.
- `ovf_exc`  out  1: one-cycle pulse with `done` on signed overflow.
- `dbg_addr`  in  5; `dbg_data`  out  32: combinational register-file read; `dbg_addr`=0 always returns 0.

## Operation
- States: IDLE, EXEC, MEM, WB.
  - IDLE: `instr_ready`=1. `instr_valid`&`instr_ready` latches `instr` into IR and moves to EXEC.
  - EXEC: ALU ports driven from IR. `alu_result`/`alu_flags` are registered at the end of the cycle. Opcode lw (100011) or sw (101011) → MEM; all others → WB.
  - MEM: `mem_req`=1, `mem_addr`=captured result, `mem_we`=1 for sw, `mem_wdata`=R[rt]. Stays in MEM until `mem_ack`. lw captures `mem_rdata` on the ack cycle. Then → WB.
  - WB: performs the writeback, pulses `done`, updates `pc`, then → IDLE.
- Operand mapping compensates for the ALU's rs/rt swap:
  - rs field (IR[25:21]) == 0: `alu_regA`=R[rs], `alu_regB`=R[rt].
  - Otherwise: `alu_regA`=R[rt], `alu_regB`=R[rs].
- Outside EXEC, `alu_instruction`=0 (sll nop) and `alu_regA`=`alu_regB`=0.
- Writeback destination:
  - R-type: IR[15:11].
  - addi/addiu/andi/ori/xori/slti/sltiu/lw: IR[20:16].
  - sw/beq/bne: no write.
- Writeback data:
  - slt/sltu/slti/sltiu write {31'b0, flags[1]}, not `alu_result`.
  - lw writes the captured `mem_rdata`.
  - All other writing instructions write the captured result.
- Overflow: for add/sub/addi with flags[0]=1, the write is suppressed and `ovf_exc` pulses. addu/subu/addiu never trap.
- Writes to R0 are discarded; R0 always reads 0.
- PC:
  - Default update is `pc`+4 (mod 2^32).
  - beq is taken if flags[2]=1; bne is taken if flags[2]=0.
  - Taken branch: `pc` = `pc`+4+({{14{imm[15]}},imm,2'b00}), 32-bit wrap.
- Unsupported opcode/funct: no write and no memory access. Retires as a nop: `done` pulses, `pc`+4.

## Timing
- Reset values:
  - `pc`=`PC_RESET`, state IDLE, `instr_ready`=1.
  - `done`=`ovf_exc`=`mem_req`=`mem_we`=0.
  - `mem_addr`=`mem_wdata`=0, ALU outputs 0, all registers 0.
- ALU instruction: accept edge T0 → EXEC in cycle T0+1 → WB in cycle T0+2 (`done`=1, register and `pc` written at the end of that cycle) → `instr_ready`=1 in cycle T0+3.
- Throughput is 3 cycles per instruction.
- lw/sw add N+1 MEM cycles when `mem_ack` arrives N cycles after `mem_req` rises.
- `mem_ack` is ignored outside MEM. `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are stable for the whole MEM stay.
- An instruction in WB sees the register-file updates of all earlier instructions. No forwarding is needed because execution is not overlapped.
- `reset` in any state returns to IDLE on the next edge. `mem_req` drops that edge and any late `mem_ack` is ignored. The in-flight instruction is discarded without `done`.
- `instr_valid` held while `instr_ready`=0 is not consumed.

## Test plan
- Reset mid-run → `pc`=`PC_RESET`, `instr_ready`=1, `done`=0, `mem_req`=0, `dbg_data`=0 for every `dbg_addr`.
- Sequence 0x20010005 (addi $1,$0,5), 0x2002FFFD (addi $2,$0,-3), 0x00221820 (add $3,$1,$2):
  - R1=5, R2=0xFFFFFFFD, R3=2.
  - During add's EXEC, `alu_regA`=0xFFFFFFFD and `alu_regB`=5.
  - Each `done` comes 2 cycles after accept; `pc`=0xC.
- Overflow: ori $1,$0,0xFFFF; sll $1,$1,15 (R1=0x7FFF8000); add $2,$1,$1 → `ovf_exc`=1 with `done`, R2 stays 0. addu of the same operands → R2=0xFFFF0000, `ovf_exc`=0.
- Compare, with R1=5 and R2=-3:
  - slt $4,$2,$1 → R4=1.
  - sltu $4,$2,$1 → R4=0.
  - slti $4,$1,6 → R4=1.
- Branch at `pc`=0x10:
  - beq $1,$1,+3 → `pc`=0x20.
  - bne $1,$1,+3 → `pc`=0x14.
  - beq with imm=-1 at 0x20 → `pc`=0x20.
- Memory:
  - sw $1,8($0) with ack 3 cycles late → `mem_req` high for 4 cycles, `mem_addr`=8, `mem_we`=1, `mem_wdata`=R1.
  - lw $5,8($0) with `mem_rdata`=0xDEADBEEF → R5=0xDEADBEEF.
  - `reset` during the MEM wait → `mem_req`=0 the next cycle, no `done`.
